// File: rtl/pairing_uart_pkg.sv
// rtl/pairing_uart_pkg.sv - shared widths and bit-FSM state type for the pairing UART loader
//   EXT_DATA_W      operand width written to the pairing core
//   EXT_ADDR_W      word address width
//   BYTES_PER_WORD  operand bytes following the address byte in a frame
//   rx_state_t      UART receive bit-FSM states
package pairing_uart_pkg;

  localparam int EXT_DATA_W     = 304;
  localparam int EXT_ADDR_W     = 8;
  localparam int BYTES_PER_WORD = 38;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with input synchronizer
//   clk, rstn   core clock, asynchronous active-low reset
//   rxd         raw serial line (idle high, asynchronous)
//   byte_valid  high on the stop-bit sample cycle when the stop bit is high
//   byte_data   received byte, valid with byte_valid
//   stop_err    high on the stop-bit sample cycle when the stop bit is low
//   idle        bit FSM is in IDLE
module uart_rx_byte
  import pairing_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err,
  output logic       idle
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  logic        sync1;
  logic        sync2;
  logic        armed;
  rx_state_t   state;
  logic [15:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        stop_sample;

  // Stop-bit outcome is reported on the sample cycle itself so the frame
  // assembler can register its strobe one cycle after the sample.
  assign stop_sample = (state == ST_STOP) && (timer == FULL_M1);
  assign byte_valid  = stop_sample && sync2;
  assign stop_err    = stop_sample && !sync2;
  assign byte_data   = shreg;
  assign idle        = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      armed   <= 1'b1;
      state   <= ST_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
      case (state)
        ST_IDLE: begin
          timer   <= '0;
          bit_idx <= '0;
          // After a low stop bit the line must go high again before a new
          // falling edge is treated as a start bit.
          if (sync2) armed <= 1'b1;
          else if (armed) state <= ST_START;
        end
        ST_START: begin
          if (timer == HALF_M1) begin
            timer <= '0;
            state <= sync2 ? ST_IDLE : ST_DATA;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_DATA: begin
          if (timer == FULL_M1) begin
            timer   <= '0;
            shreg   <= {sync2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_STOP: begin
          if (timer == FULL_M1) begin
            timer <= '0;
            state <= ST_IDLE;
            if (!sync2) armed <= 1'b0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pairing_uart_loader.sv
// rtl/pairing_uart_loader.sv - UART frame loader driving the pairing core external input port
//   clk, rstn   core clock, asynchronous active-low reset
//   uart_rxd    serial line, idle high
//   extin_addr  address of the last completed frame
//   extin_data  304-bit operand of the last completed frame
//   extin_en    one-cycle write strobe
//   frame_err   one-cycle pulse on bad stop bit or partial-frame timeout
//   busy        a frame or byte is partially received
module pairing_uart_loader
  import pairing_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 16 * CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  uart_rxd,
  output logic [EXT_ADDR_W-1:0] extin_addr,
  output logic [EXT_DATA_W-1:0] extin_data,
  output logic                  extin_en,
  output logic                  frame_err,
  output logic                  busy
);

  localparam logic [5:0]  LAST_BYTE = 6'(BYTES_PER_WORD);
  localparam logic [31:0] TO_M1     = 32'(TIMEOUT_CLKS - 1);

  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_stop_err;
  logic                  rx_idle;
  logic [5:0]            byte_cnt;
  logic [EXT_ADDR_W-1:0] addr_asm;
  logic [EXT_DATA_W-1:0] data_asm;
  logic [EXT_DATA_W-1:0] data_next;
  logic [31:0]           idle_cnt;
  logic                  timeout_hit;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rstn      (rstn),
    .rxd       (uart_rxd),
    .byte_valid(rx_valid),
    .byte_data (rx_data),
    .stop_err  (rx_stop_err),
    .idle      (rx_idle)
  );

  // Operand arrives most-significant byte first, so each byte enters at the bottom.
  assign data_next   = {data_asm[EXT_DATA_W-9:0], rx_data};
  assign timeout_hit = (byte_cnt != 6'd0) && rx_idle && (idle_cnt == TO_M1);
  assign busy        = (byte_cnt != 6'd0) || !rx_idle;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt   <= '0;
      addr_asm   <= '0;
      data_asm   <= '0;
      idle_cnt   <= '0;
      extin_addr <= '0;
      extin_data <= '0;
      extin_en   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      extin_en  <= 1'b0;
      frame_err <= rx_stop_err || timeout_hit;

      // Idle time only accumulates between bytes of a partial frame; any
      // start detect takes the bit FSM out of IDLE and clears it.
      if ((byte_cnt != 6'd0) && rx_idle && !timeout_hit) idle_cnt <= idle_cnt + 32'd1;
      else idle_cnt <= '0;

      if (rx_stop_err || timeout_hit) begin
        byte_cnt <= '0;
      end else if (rx_valid) begin
        if (byte_cnt == 6'd0) begin
          addr_asm <= rx_data;
          byte_cnt <= 6'd1;
        end else begin
          data_asm <= data_next;
          if (byte_cnt == LAST_BYTE) begin
            extin_addr <= addr_asm;
            extin_data <= data_next;
            extin_en   <= 1'b1;
            byte_cnt   <= '0;
          end else begin
            byte_cnt <= byte_cnt + 6'd1;
          end
        end
      end
    end
  end

endmodule
